// File: rtl/ldo_enable_sequencer_pkg.sv
// ldo_enable_sequencer_pkg: state encoding and width helpers shared by the LDO sequencer and its status logic.
package ldo_enable_sequencer_pkg;
   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_ON     = 3'd3,
      ST_COOL   = 3'd4,
      ST_FAULT  = 3'd5
   } ldo_state_e;

   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/ldo_enable_sequencer_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end
endmodule

// File: rtl/ldo_enable_sequencer.sv
// ldo_enable_sequencer: gated LDO enable with settle blanking, power-good timeout,
// retry cool-down and a sticky fault cleared only by software.
module ldo_enable_sequencer
   import ldo_enable_sequencer_pkg::*;
#(
   parameter int SETTLE_CYC   = 16,
   parameter int PG_TIMEOUT   = 64,
   parameter int COOLDOWN_CYC = 32,
   parameter int MAX_RETRY    = 3
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            req,
   input  logic                            vdda_ok,
   input  logic                            pg,
   input  logic                            clr_fault,
   output logic                            EN,
   output logic                            ENB,
   output logic                            ready,
   output logic                            fault,
   output logic [clog2(MAX_RETRY+1)-1:0]   retry_cnt,
   output logic [2:0]                      state
);
   localparam int RW = clog2(MAX_RETRY + 1);
   localparam int TW = clog2(max3(SETTLE_CYC, PG_TIMEOUT, COOLDOWN_CYC) + 1);

   ldo_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d, retry_inc;
   logic          en_q, enb_q, ready_q, fault_q, en_d;
   logic          pg_s, go, expired, failed;

   sync_2ff u_pg_sync (
      .clk_i (clk),
      .rst_ni(resetn),
      .d_i   (pg),
      .q_o   (pg_s)
   );

   assign go        = req && vdda_ok;
   assign expired   = timer_q == TW'(1);
   assign retry_inc = retry_q + RW'(1);
   assign failed    = !pg_s && ((state_q == ST_CHECK && expired) || state_q == ST_ON);
   assign en_d      = state_d inside {ST_SETTLE, ST_CHECK, ST_ON};

   always_comb begin
      retry_d = retry_q;
      case (state_q)
         ST_OFF:    state_d = go ? ST_SETTLE : ST_OFF;
         ST_SETTLE: state_d = expired ? ST_CHECK : ST_SETTLE;
         ST_CHECK:  state_d = pg_s ? ST_ON : ST_CHECK;
         ST_ON:     state_d = ST_ON;
         ST_COOL:   state_d = expired ? ST_SETTLE : ST_COOL;
         ST_FAULT:  state_d = clr_fault ? ST_OFF : ST_FAULT;
         default:   state_d = ST_OFF;
      endcase
      if (failed) begin
         retry_d = retry_inc;
         state_d = (retry_inc == RW'(MAX_RETRY)) ? ST_FAULT : ST_COOL;
      end
      if (state_d == ST_ON || (state_q == ST_FAULT && clr_fault)) retry_d = '0;
      // Losing the supply or the request aborts everything except a latched fault.
      if (state_q != ST_FAULT && !go) begin
         state_d = ST_OFF;
         retry_d = '0;
      end
   end

   always_comb begin
      timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
      if (state_d != state_q)
         timer_d = (state_d == ST_SETTLE) ? TW'(SETTLE_CYC) :
                   (state_d == ST_CHECK)  ? TW'(PG_TIMEOUT) :
                   (state_d == ST_COOL)   ? TW'(COOLDOWN_CYC) : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_OFF;
         timer_q <= '0;
         retry_q <= '0;
         en_q    <= 1'b0;
         enb_q   <= 1'b1;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         en_q    <= en_d;
         enb_q   <= ~en_d;
         ready_q <= state_d == ST_ON;
         fault_q <= state_d == ST_FAULT;
      end
   end

   assign EN        = en_q;
   assign ENB       = enb_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign state     = state_q;
endmodule

// File: tb/tb_ldo_enable_sequencer.sv
// tb_ldo_enable_sequencer: randomized power-up runs scored against an event-timeline reference model.
module tb_ldo_enable_sequencer;
   localparam int S = 16, T = 64, C = 32, MR = 3;
   localparam int RW = $clog2(MR + 1);
   localparam int VW = 3 + RW + 4;
   localparam int NONE = 32'h7fffffff;
   localparam int OFF = 0, SETTLE = 1, CHECK = 2, ON = 3, COOL = 4, FAULT = 5;

   typedef struct {
      int            edge_n;
      logic [VW-1:0] v;
   } ev_t;

   logic          clk = 1'b0, resetn = 1'b1, req = 1'b0, vdda_ok = 1'b1, pg = 1'b0, clr_fault = 1'b0;
   logic          EN, ENB, ready, fault;
   logic [RW-1:0] retry_cnt;
   logic [2:0]    state;
   logic [VW-1:0] act;
   int            cyc = 0, n_cmp = 0, n_bad = 0, abort_e = NONE;
   ev_t           exp_q[$];

   ldo_enable_sequencer #(
      .SETTLE_CYC  (S),
      .PG_TIMEOUT  (T),
      .COOLDOWN_CYC(C),
      .MAX_RETRY   (MR)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (req),
      .vdda_ok  (vdda_ok),
      .pg       (pg),
      .clr_fault(clr_fault),
      .EN       (EN),
      .ENB      (ENB),
      .ready    (ready),
      .fault    (fault),
      .retry_cnt(retry_cnt),
      .state    (state)
   );

   assign act = {state, retry_cnt, fault, ready, ENB, EN};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [VW-1:0] vec(int st, int r);
      logic en;
      en = (st == SETTLE) || (st == CHECK) || (st == ON);
      return {3'(st), RW'(r), st == FAULT, st == ON, !en, en};
   endfunction

   function automatic void check(string name, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endfunction

   // Queue the output change expected at edge e unless an abort lands first.
   function automatic bit ev(int e, int st, int r);
      if (e >= abort_e) return 1'b1;
      exp_q.push_back('{edge_n: e, v: vec(st, r)});
      return 1'b0;
   endfunction

   task automatic wait_to(int e);
      while (cyc < e) @(negedge clk);
   endtask

   // Monitor: every output change must match the next queued expected event.
   initial begin
      logic [VW-1:0] prev;
      ev_t           e;
      @(posedge resetn);
      prev = vec(OFF, 0);
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
            e = exp_q.pop_front();
            check("missed_event_cycle", cyc, e.edge_n);
            prev = e.v;
         end
         if (act != prev) begin
            if (exp_q.size() == 0) check("unexpected_change", int'(act), int'(prev));
            else begin
               e = exp_q.pop_front();
               check("event_cycle", cyc, e.edge_n);
               check("event_outputs", int'(act), int'(e.v));
               prev = e.v;
            end
         end
      end
   end

   // One power-up sequence: pass[k] says whether pg is good during attempt k.
   task automatic run_seq(logic [7:0] pass, bit drop_on, int abort_off, bit use_vdda);
      int  t, f, o, r, k, fe, n;
      bit  faulted, dropped;
      r = 0; k = 0; fe = 0; faulted = 0; dropped = 0;
      pg = pass[0];
      req = 1'b1;
      vdda_ok = 1'b1;
      t = cyc + 1;
      abort_e = (abort_off > 0) ? t + abort_off : NONE;
      while (1) begin
         if (ev(t, SETTLE, r) || ev(t + S, CHECK, r)) break;
         if (pass[k]) begin
            o = t + S + 1;
            r = 0;
            if (ev(o, ON, 0)) break;
            if (!drop_on || dropped) begin
               if (abort_e == NONE) abort_e = o + int'($urandom_range(1, 20));
               break;
            end
            dropped = 1;
            f = o + int'($urandom_range(1, 10)) + 3;
            if (f >= abort_e) break;
            wait_to(f - 3);
            pg = 1'b0;
         end else f = t + S + T;
         r++;
         k++;
         if (ev(f, (r == MR) ? FAULT : COOL, r)) break;
         if (r == MR) begin
            faulted = 1;
            fe = f;
            break;
         end
         wait_to(f);
         pg = pass[k];
         t = f + C;
      end
      if (faulted) begin
         abort_e = NONE;
         wait_to(fe + int'($urandom_range(1, 4)));
         if (use_vdda) vdda_ok = 1'b0; else req = 1'b0;
         repeat (3) begin
            @(negedge clk);
            req = ~req;
         end
         @(negedge clk);
         n = cyc;
         vdda_ok = 1'b1;
         clr_fault = 1'b1;
         req = 1'($urandom_range(0, 1));
         void'(ev(n + 1, OFF, 0));
         if (req) begin
            void'(ev(n + 2, SETTLE, 0));
            void'(ev(n + 3, OFF, 0));
         end
         @(negedge clk);
         clr_fault = 1'b0;
         @(negedge clk);
         req = 1'b0;
      end else begin
         wait_to(abort_e - 1);
         if (use_vdda) vdda_ok = 1'b0; else req = 1'b0;
         abort_e = NONE;
         void'(ev(cyc + 1, OFF, 0));
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
   endtask

   initial begin
      int t;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      check("reset_outputs", int'(act), int'(vec(OFF, 0)));
      run_seq(8'hFF, 1'b0, 0, 1'b0);
      run_seq(8'h00, 1'b0, 0, 1'b0);
      run_seq(8'h02, 1'b0, 0, 1'b0);
      run_seq(8'hFF, 1'b1, 0, 1'b0);
      run_seq(8'hFF, 1'b0, 8, 1'b1);
      run_seq(8'hFF, 1'b0, 30, 1'b1);
      repeat (16)
         run_seq(8'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 400)) : 0, 1'($urandom));
      // Asynchronous reset in the middle of CHECK.
      pg = 1'b0;
      req = 1'b1;
      vdda_ok = 1'b1;
      t = cyc + 1;
      abort_e = NONE;
      void'(ev(t, SETTLE, 0));
      void'(ev(t + S, CHECK, 0));
      wait_to(t + S + 10);
      @(posedge clk);
      #3 resetn = 1'b0;
      void'(ev(cyc, OFF, 0));
      #1;
      check("async_reset_EN", int'(EN), 0);
      check("async_reset_ENB", int'(ENB), 1);
      check("async_reset_ready", int'(ready), 0);
      req = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_outputs", int'(act), int'(vec(OFF, 0)));
      run_seq(8'hFF, 1'b0, 0, 1'b0);
      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ldo_enable_sequencer.md
# ldo_enable_sequencer

Digital power-up sequencer that sits directly upstream of the 3.3 V-input analog LDO and drives its complementary EN/ENB pins. It gates enable on a valid analog supply and applies a settle (blanking) interval. It then checks the LDO power-good comparator within a timeout and retries with a cool-down. After MAX_RETRY consecutive failures it latches a sticky fault that only software can clear.

## Interface
Parameters:
- SETTLE_CYC, 16: cycles EN is held before power-good is examined (blanking).
- PG_TIMEOUT, 64: cycles allowed in CHECK for synchronized pg to go high.
- COOLDOWN_CYC, 32: cycles EN is held low between attempts.
- MAX_RETRY, 3: consecutive failed attempts before FAULT (≥1).

Ports:
- clk  input  1  sequencer clock.
- resetn  input  1  reset; asynchronous assert, active-low.
- req  input  1  software request to power the LDO on (level).
- vdda_ok  input  1  analog-supply-good from brownout detector, already synchronous to clk.
- pg  input  1  LDO output power-good comparator, asynchronous to clk.
- clr_fault  input  1  single-cycle pulse that clears FAULT.
- EN  output  1  LDO enable, registered.
- ENB  output  1  LDO enable complement, registered, always ~EN.
- ready  output  1  LDO up and power-good, registered.
- fault  output  1  sticky failure flag, registered.
- retry_cnt  output  clog2(MAX_RETRY+1)  failed attempts in the current sequence.
- state  output  3  current FSM state, for debug/status.

## Operation
- Reset values: state=OFF, EN=0, ENB=1, ready=0, fault=0, retry_cnt=0, timer=0, synchronizer flops=0.
- pg passes through a 2-flop synchronizer. pg_s is the synchronized value, and all pg decisions use pg_s.
- Single shared down-timer, width clog2(max(SETTLE_CYC,PG_TIMEOUT,COOLDOWN_CYC)+1). It is loaded on every state entry and counts down by 1 per cycle. "Expired" means timer==1 in that cycle.
- States and transitions (priority top-down within each state):
  - OFF: EN=0. If req & vdda_ok → SETTLE.
  - SETTLE: EN=1, pg_s ignored. On expiry → CHECK.
  - CHECK: EN=1. If pg_s → ON. Else on expiry → failure.
  - ON: EN=1, ready=1. If pg_s==0 → failure.
  - COOL: EN=0. On expiry → SETTLE.
  - FAULT: EN=0, fault=1. req and vdda_ok are ignored. Only clr_fault → OFF, with retry_cnt:=0 and fault:=0.
- Failure: retry_cnt+1. If the new value equals MAX_RETRY → FAULT. Otherwise → COOL.
- Global overrides in every state except FAULT, highest priority first:
  - vdda_ok==0 → OFF.
  - req==0 → OFF.
  - Both clear retry_cnt and drop EN/ready on the next edge.
- Entering ON clears retry_cnt.
- EN/ENB come from a single register pair and are never equal in any cycle, including reset.

## Timing
- All outputs are registered and reflect the state entered at the edge.
- OFF→SETTLE: EN rises on the first edge where req & vdda_ok are sampled high (1-cycle latency).
- EN stays high exactly SETTLE_CYC cycles in SETTLE, then the first CHECK cycle.
- pg latency: 2 cycles through the synchronizer. A pg rising edge is visible in CHECK at the earliest 2 cycles later, and ready rises on the following edge.
- If pg is high throughout, ready rises exactly SETTLE_CYC+1 cycles after EN rises.
- CHECK lasts at most PG_TIMEOUT cycles.
- COOL holds EN low exactly COOLDOWN_CYC cycles.
- If pg drops in ON, ready and EN fall 3 edges after pg falls (2 sync + 1 register).
- If req or vdda_ok is dropped in any non-FAULT state, EN falls on the next edge and any pending timer is discarded.
- Asynchronous reset mid-sequence forces EN=0 and ENB=1 immediately, without waiting for clk.
- If clr_fault and req are both high in FAULT: go to OFF, then to SETTLE on the following edge if req & vdda_ok.

## Structure
- Shared package/include: state encoding localparams (OFF=0, SETTLE=1, CHECK=2, ON=3, COOL=4, FAULT=5) and a clog2 function, reused by the LDO status register block.
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with async active-low reset, instanced for pg.
- Everything else (FSM, timer, retry counter, output registers) stays flat in ldo_enable_sequencer.

## Test plan
- Reset, then req=1, vdda_ok=1, pg tied high:
  - EN=1/ENB=0 one cycle after req.
  - ready=1 exactly 17 cycles after EN rises.
  - retry_cnt=0, fault=0.
- pg held low:
  - Three attempts, each EN-high for 16+64 cycles, separated by 32-cycle EN-low cool-downs.
  - Then state=FAULT, fault=1, retry_cnt=3, EN=0.
  - req toggling has no effect.
  - clr_fault pulse → OFF, fault=0, retry_cnt=0.
- pg low on first attempt, high during second:
  - retry_cnt=1 during the second attempt.
  - ready=1 at the end, and retry_cnt returns to 0 on entering ON.
- In ON, pg falls:
  - ready and EN drop 3 cycles later.
  - COOL for 32 cycles, then EN re-asserts with retry_cnt=1.
- vdda_ok deasserted mid-SETTLE and mid-ON:
  - EN=0 next edge, state=OFF.
  - No retry counted.
  - Sequence restarts on vdda_ok return while req=1.
- resetn pulsed low mid-CHECK, asynchronous to clk:
  - EN=0, ENB=1, ready=0 with no clock edge.
  - All state returns to reset values.
